// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/stall control bundle between pipeline registers and the sequencer
// Optional HAZARD_PERF_EN adds the stall_cycles/flush_cycles counters to the bundle.
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] IFID_RS;
    logic [REG_ADDR_W-1:0] IFID_RT;
    logic [REG_ADDR_W-1:0] IDEX_RT;
    logic                  IDEX_MemRead;
    logic                  Branch_taken;
    logic                  mul_start;
    logic                  mul_done;
    logic                  PC_WRITE;
    logic                  IFID_WRITE;
    logic                  IFID_FLUSH;
    logic                  IDEX_FLUSH;
    logic                  IDEX_HOLD;
    logic                  mul_timeout;
`ifdef HAZARD_PERF_EN
    logic [15:0]           stall_cycles;
    logic [15:0]           flush_cycles;

    modport master (
        output IFID_RS, IFID_RT, IDEX_RT, IDEX_MemRead, Branch_taken, mul_start, mul_done,
        input  PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, IDEX_HOLD, mul_timeout,
        input  stall_cycles, flush_cycles
    );
    modport slave (
        input  IFID_RS, IFID_RT, IDEX_RT, IDEX_MemRead, Branch_taken, mul_start, mul_done,
        output PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, IDEX_HOLD, mul_timeout,
        output stall_cycles, flush_cycles
    );
`else
    modport master (
        output IFID_RS, IFID_RT, IDEX_RT, IDEX_MemRead, Branch_taken, mul_start, mul_done,
        input  PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, IDEX_HOLD, mul_timeout
    );
    modport slave (
        input  IFID_RS, IFID_RT, IDEX_RT, IDEX_MemRead, Branch_taken, mul_start, mul_done,
        output PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, IDEX_HOLD, mul_timeout
    );
`endif
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use bubble, branch flush window and multiplier freeze sequencer
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W     = 4,
    parameter int BRANCH_PENALTY = 2,
    parameter int MUL_MAX_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, BR_FLUSH, MUL_WAIT} state_t;

    state_t     state, state_n;
    logic [2:0] flush_cnt, flush_cnt_n;
    logic [7:0] mul_cnt, mul_cnt_n;
    logic       timeout_q, timeout_set;
    logic       load_use;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, idex_hold_raw;

    logic [REG_ADDR_W-1:0] ex_rt;
    assign ex_rt    = hz.IDEX_RT;
    assign load_use = hz.IDEX_MemRead && ((ex_rt == hz.IFID_RS) || (ex_rt == hz.IFID_RT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            mul_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            mul_cnt   <= mul_cnt_n;
            if (timeout_set)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_n       = state;
        flush_cnt_n   = flush_cnt;
        mul_cnt_n     = mul_cnt;
        timeout_set   = 1'b0;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        idex_hold_raw = 1'b0;
        case (state)
            RUN: begin
                if (hz.Branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_n     = BR_FLUSH;
                        flush_cnt_n = 3'(BRANCH_PENALTY - 1);
                    end
                end else if (hz.mul_start && !hz.mul_done) begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_hold_raw = 1'b1;
                    state_n       = MUL_WAIT;
                    mul_cnt_n     = 8'd1;
                end else if (load_use) begin
                    // The bubble clears MemRead in EX, so this stall self-terminates.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            BR_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (flush_cnt != 3'd0)
                    flush_cnt_n = flush_cnt - 3'd1;
                if (flush_cnt <= 3'd1)
                    state_n = RUN;
            end
            MUL_WAIT: begin
                if (hz.mul_done) begin
                    state_n   = RUN;
                    mul_cnt_n = 8'd0;
                end else if (mul_cnt >= 8'(MUL_MAX_CYCLES)) begin
                    timeout_set = 1'b1;
                    state_n     = RUN;
                    mul_cnt_n   = 8'd0;
                end else begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_hold_raw = 1'b1;
                    mul_cnt_n     = mul_cnt + 8'd1;
                end
            end
            default: state_n = RUN;
        endcase
        if (rst) begin
            pc_write      = 1'b1;
            ifid_write    = 1'b1;
            ifid_flush    = 1'b0;
            idex_flush    = 1'b0;
            idex_hold_raw = 1'b0;
        end
    end

    assign hz.PC_WRITE    = pc_write;
    assign hz.IFID_WRITE  = ifid_write;
    assign hz.IFID_FLUSH  = ifid_flush;
    assign hz.IDEX_FLUSH  = idex_flush;
    assign hz.IDEX_HOLD   = idex_hold_raw & ~idex_flush;
    assign hz.mul_timeout = timeout_q & ~rst;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_write && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (idex_flush && flush_cycles != 16'hFFFF)
                flush_cycles <= flush_cycles + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_cycles = flush_cycles;
`endif
endmodule
